// File: rtl/obi_master_be_if.sv
// obi_master_be_if - bundles the core-side command/response channel and the
// OBI A/R channels of the byte-enabled OBI manager.
//   master : view of the manager (obi_master_be) - consumes commands, emits
//            responses, drives OBI requests, consumes OBI responses.
//   slave  : view of the environment (controller + OBI subordinate).
// Signal names keep the manager's point of view (_i = into the manager).
interface obi_master_be_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // command channel
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic                    cmd_we_i;
  logic [1:0]              cmd_size_i;
  logic                    cmd_unsigned_i;
  logic [DATA_WIDTH-1:0]   cmd_wdata_i;
  // response channel
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    rsp_misaligned_o;
  // OBI A channel
  logic                    obi_req_o;
  logic                    obi_gnt_i;
  logic [ADDR_WIDTH-1:0]   obi_addr_o;
  logic                    obi_we_o;
  logic [DATA_WIDTH/8-1:0] obi_be_o;
  logic [DATA_WIDTH-1:0]   obi_wdata_o;
  // OBI R channel
  logic                    obi_rvalid_i;
  logic                    obi_rready_o;
  logic [DATA_WIDTH-1:0]   obi_rdata_i;
  logic                    obi_err_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_size_i, cmd_unsigned_i,
           cmd_wdata_i, rsp_ready_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
           obi_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
           obi_rready_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_size_i, cmd_unsigned_i,
           cmd_wdata_i, rsp_ready_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
           obi_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
           obi_rready_o
  );
endinterface

// File: rtl/obi_master_be.sv
// obi_master_be - byte-enabled OBI manager, one outstanding transaction.
// Accepts single load/store commands, issues an OBI A-channel request with
// byte enables and lane-replicated write data, then extracts and sign/zero
// extends the R-channel read data. Misaligned commands are answered locally
// with err=1, misaligned=1 and never reach the bus.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous, active-high reset
//   bus      - obi_master_be_if.master (command, response, OBI A/R channels)
// Only DATA_WIDTH = 32 (four byte lanes) is supported.

// One byte lane: its byte-enable bit and its slice of the replicated
// write data, for the registered size / address offset.
module obi_be_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic [1:0] size_i,
  input  logic [1:0] a_i,
  input  logic [7:0] byte_i,       // wdata[7:0]
  input  logic [7:0] half_byte_i,  // wdata byte this lane takes in a half store
  input  logic [7:0] word_byte_i,  // wdata byte this lane takes in a word store
  output logic       be_o,
  output logic [7:0] wbyte_o
);
  always_comb begin
    be_o    = 1'b0;
    wbyte_o = word_byte_i;
    case (size_i)
      2'b00: begin
        be_o    = (a_i == LANE);
        wbyte_o = byte_i;
      end
      2'b01: begin
        // aligned half: a[1] picks the lower or upper lane pair
        be_o    = (a_i[1] == LANE[1]);
        wbyte_o = half_byte_i;
      end
      2'b10: begin
        be_o    = 1'b1;
        wbyte_o = word_byte_i;
      end
      default: begin
        // reserved size is rejected before REQ, so nothing is enabled
        be_o    = 1'b0;
        wbyte_o = word_byte_i;
      end
    endcase
  end
endmodule

module obi_master_be #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  obi_master_be_if.master bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                  err;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  state_e state_q, state_d;
  cmd_t   cmd_q;
  rsp_t   rsp_q;

  logic cmd_ready, cmd_fire, misaligned;
  logic req, rready, rsp_valid;

  logic [1:0]                  a;
  logic [NUM_LANES-1:0]        be;
  logic [NUM_LANES-1:0][7:0]   wdata_rep;
  logic [DATA_WIDTH-1:0]       wdata_flat;
  logic [7:0]                  rd_byte;
  logic [15:0]                 rd_half;
  logic [DATA_WIDTH-1:0]       rdata_ext;

  // ---------------------------------------------------------------------------
  // Command acceptance and local alignment check
  // ---------------------------------------------------------------------------
  assign cmd_fire = bus.cmd_valid_i && cmd_ready;

  always_comb begin
    misaligned = 1'b0;
    case (bus.cmd_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.cmd_addr_i[0];
      2'b10:   misaligned = (bus.cmd_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    // cmd_ready stays low while reset is held so nothing is accepted then
    cmd_ready = 1'b0;
    req       = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !reset_i;
        if (cmd_fire) state_d = misaligned ? RSP : REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.obi_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        rready = 1'b1;
        if (bus.obi_rvalid_i) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command / response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      if (cmd_fire) begin
        cmd_q.addr  <= bus.cmd_addr_i;
        cmd_q.we    <= bus.cmd_we_i;
        cmd_q.size  <= bus.cmd_size_i;
        cmd_q.uns   <= bus.cmd_unsigned_i;
        cmd_q.wdata <= bus.cmd_wdata_i;
        // a misaligned command is answered straight from here
        rsp_q.err        <= misaligned;
        rsp_q.misaligned <= misaligned;
        rsp_q.rdata      <= '0;
      end
      if (rready && bus.obi_rvalid_i) begin
        rsp_q.err        <= bus.obi_err_i;
        rsp_q.misaligned <= 1'b0;
        rsp_q.rdata      <= (bus.obi_err_i || cmd_q.we) ? '0 : rdata_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane byte enables and replicated write data
  // ---------------------------------------------------------------------------
  assign a = cmd_q.addr[1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    obi_be_lane #(.LANE(2'(l))) u_lane (
      .size_i      (cmd_q.size),
      .a_i         (a),
      .byte_i      (cmd_q.wdata[7:0]),
      .half_byte_i (cmd_q.wdata[8*(l%2) +: 8]),
      .word_byte_i (cmd_q.wdata[8*l +: 8]),
      .be_o        (be[l]),
      .wbyte_o     (wdata_rep[l])
    );
  end

  assign wdata_flat = wdata_rep;

  // ---------------------------------------------------------------------------
  // Read data extraction and extension
  // ---------------------------------------------------------------------------
  assign rd_byte = bus.obi_rdata_i[{a, 3'b000} +: 8];
  assign rd_half = bus.obi_rdata_i[{a[1], 4'b0000} +: 16];

  always_comb begin
    rdata_ext = bus.obi_rdata_i;
    case (cmd_q.size)
      2'b00: rdata_ext = cmd_q.uns ? {{(DATA_WIDTH-8){1'b0}}, rd_byte}
                                   : {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      2'b01: rdata_ext = cmd_q.uns ? {{(DATA_WIDTH-16){1'b0}}, rd_half}
                                   : {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      default: rdata_ext = bus.obi_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: A channel only carries data while requesting, response fields
  // only while valid, so everything idles at zero otherwise.
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready_o      = cmd_ready;
  assign bus.obi_req_o        = req;
  assign bus.obi_addr_o       = req ? {cmd_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.obi_we_o         = req && cmd_q.we;
  assign bus.obi_be_o         = req ? be : '0;
  assign bus.obi_wdata_o      = req ? wdata_flat : '0;
  assign bus.obi_rready_o     = rready;
  assign bus.rsp_valid_o      = rsp_valid;
  assign bus.rsp_rdata_o      = rsp_valid ? rsp_q.rdata : '0;
  assign bus.rsp_err_o        = rsp_valid && rsp_q.err;
  assign bus.rsp_misaligned_o = rsp_valid && rsp_q.misaligned;
endmodule

// File: tb/tb_obi_master_be.sv
// Directed bench for obi_master_be: drives commands and a scripted OBI
// subordinate, queues the expected response when a command is issued and
// compares it when the manager presents the response.
module tb_obi_master_be;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obi_master_be_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  obi_master_be #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ------------------------------------------------------
  function automatic logic model_mis(input logic [31:0] ad, input logic [1:0] s);
    case (s)
      2'b00:   return 1'b0;
      2'b01:   return ad[0];
      2'b10:   return ad[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] ad, input logic [1:0] s);
    logic [3:0] one = 4'b0001;
    logic [3:0] two = 4'b0011;
    case (s)
      2'b00:   return one << ad[1:0];
      2'b01:   return two << ad[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] s, input logic [31:0] wd);
    case (s)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] ad, input logic [1:0] s,
                                           input logic u, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * ad[1:0]);
    case (s)
      2'b00:   return u ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic check_all_zero(input string tag, input logic exp_ready);
    check({tag, ":cmd_ready"},  32'(bus.cmd_ready_o), 32'(exp_ready));
    check({tag, ":obi_req"},    32'(bus.obi_req_o), 0);
    check({tag, ":obi_addr"},   bus.obi_addr_o, 0);
    check({tag, ":obi_we"},     32'(bus.obi_we_o), 0);
    check({tag, ":obi_be"},     32'(bus.obi_be_o), 0);
    check({tag, ":obi_wdata"},  bus.obi_wdata_o, 0);
    check({tag, ":obi_rready"}, 32'(bus.obi_rready_o), 0);
    check({tag, ":rsp_valid"},  32'(bus.rsp_valid_o), 0);
    check({tag, ":rsp_rdata"},  bus.rsp_rdata_o, 0);
    check({tag, ":rsp_err"},    32'(bus.rsp_err_o), 0);
    check({tag, ":rsp_mis"},    32'(bus.rsp_misaligned_o), 0);
  endtask

  // One full command: gw cycles without grant, rw cycles without rvalid,
  // sw cycles with rsp_ready low. Stray gnt/rvalid are driven in states
  // where they must be ignored.
  task automatic do_txn(input string nm, input logic [31:0] ad, input logic we,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rd,
                        input logic berr, input int sw);
    logic mis;
    exp_t e, got;
    mis     = model_mis(ad, sz);
    e.mis   = mis;
    e.err   = mis | berr;
    e.rdata = (mis || berr || we) ? 32'h0 : model_rd(ad, sz, u, rd);

    check({nm, ":cmd_ready"}, 32'(bus.cmd_ready_o), 1);
    bus.cmd_valid_i    = 1'b1;
    bus.cmd_addr_i     = ad;
    bus.cmd_we_i       = we;
    bus.cmd_size_i     = sz;
    bus.cmd_unsigned_i = u;
    bus.cmd_wdata_i    = wd;
    sb.push_back(e);
    step();
    // scramble command inputs: the manager must work from its registers
    bus.cmd_valid_i    = 1'b0;
    bus.cmd_addr_i     = $urandom;
    bus.cmd_wdata_i    = $urandom;
    bus.cmd_we_i       = ~we;
    bus.cmd_unsigned_i = ~u;
    bus.cmd_size_i     = 2'($urandom);

    if (!mis) begin
      for (int g = 0; g <= gw; g++) begin
        check({nm, ":req"},       32'(bus.obi_req_o), 1);
        check({nm, ":addr"},      bus.obi_addr_o, {ad[31:2], 2'b00});
        check({nm, ":we"},        32'(bus.obi_we_o), 32'(we));
        check({nm, ":be"},        32'(bus.obi_be_o), 32'(model_be(ad, sz)));
        check({nm, ":wdata"},     bus.obi_wdata_o, model_wd(sz, wd));
        check({nm, ":rready_req"}, 32'(bus.obi_rready_o), 0);
        check({nm, ":cmd_ready_req"}, 32'(bus.cmd_ready_o), 0);
        check({nm, ":rsp_valid_req"}, 32'(bus.rsp_valid_o), 0);
        bus.obi_gnt_i    = (g == gw);
        bus.obi_rvalid_i = 1'b1;
        bus.obi_err_i    = 1'b1;
        bus.obi_rdata_i  = $urandom;
        step();
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;
      end
      for (int r = 0; r <= rw; r++) begin
        check({nm, ":rready"},        32'(bus.obi_rready_o), 1);
        check({nm, ":req_wait"},      32'(bus.obi_req_o), 0);
        check({nm, ":rsp_valid_wait"}, 32'(bus.rsp_valid_o), 0);
        bus.obi_gnt_i = 1'b1;
        if (r == rw) begin
          bus.obi_rvalid_i = 1'b1;
          bus.obi_rdata_i  = rd;
          bus.obi_err_i    = berr;
        end else begin
          bus.obi_rdata_i  = $urandom;
        end
        step();
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;
        bus.obi_rdata_i  = $urandom;
      end
    end

    for (int s = 0; s <= sw; s++) begin
      if (sb.size() == 0) begin
        check({nm, ":sb_empty"}, 0, 1);
        break;
      end
      got = sb[0];
      check({nm, ":rsp_valid"},  32'(bus.rsp_valid_o), 1);
      check({nm, ":cmd_ready_rsp"}, 32'(bus.cmd_ready_o), 0);
      check({nm, ":req_rsp"},    32'(bus.obi_req_o), 0);
      check({nm, ":rready_rsp"}, 32'(bus.obi_rready_o), 0);
      check({nm, ":rsp_rdata"},  bus.rsp_rdata_o, got.rdata);
      check({nm, ":rsp_err"},    32'(bus.rsp_err_o), 32'(got.err));
      check({nm, ":rsp_mis"},    32'(bus.rsp_misaligned_o), 32'(got.mis));
      bus.rsp_ready_i  = (s == sw);
      bus.obi_rvalid_i = 1'b1;
      bus.obi_err_i    = ~berr;
      bus.obi_gnt_i    = 1'b1;
      if (s == sw) void'(sb.pop_front());
      step();
      bus.rsp_ready_i  = 1'b0;
      bus.obi_rvalid_i = 1'b0;
      bus.obi_err_i    = 1'b0;
      bus.obi_gnt_i    = 1'b0;
    end
    check({nm, ":back_idle"},  32'(bus.cmd_ready_o), 1);
    check({nm, ":rsp_dropped"}, 32'(bus.rsp_valid_o), 0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.cmd_valid_i    = 1'b0;
    bus.cmd_addr_i     = '0;
    bus.cmd_we_i       = 1'b0;
    bus.cmd_size_i     = 2'b00;
    bus.cmd_unsigned_i = 1'b0;
    bus.cmd_wdata_i    = '0;
    bus.rsp_ready_i    = 1'b0;
    bus.obi_gnt_i      = 1'b0;
    bus.obi_rvalid_i   = 1'b0;
    bus.obi_rdata_i    = '0;
    bus.obi_err_i      = 1'b0;

    // reset
    step();
    check_all_zero("reset", 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_all_zero("post_reset", 1'b1);

    // word load, best-case latency
    do_txn("word_ld", 32'h0000_0008, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0);
    // signed / unsigned byte load from the top lane
    do_txn("sb_ld",   32'h0000_0003, 1'b0, 2'b00, 1'b0, 32'h0, 0, 0, 32'h80123456, 1'b0, 0);
    do_txn("ub_ld",   32'h0000_0003, 1'b0, 2'b00, 1'b1, 32'h0, 0, 0, 32'h80123456, 1'b0, 0);
    // half store with grant withheld 3 cycles
    do_txn("h_st",    32'h0000_0006, 1'b1, 2'b01, 1'b0, 32'h0000ABCD, 3, 0, 32'h11223344, 1'b0, 0);
    // misaligned / reserved commands
    do_txn("mis_w",   32'h0000_0002, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 0);
    do_txn("mis_rsv", 32'h0000_0000, 1'b0, 2'b11, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 0);
    do_txn("mis_h",   32'h0000_0101, 1'b1, 2'b01, 1'b0, 32'h5555, 0, 0, 32'h0, 1'b0, 2);
    // bus error with a 5-cycle response stall
    do_txn("bus_err", 32'h0000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, 32'hCAFEF00D, 1'b1, 5);
    // byte store, rvalid delayed
    do_txn("b_st",    32'h0000_0041, 1'b1, 2'b00, 1'b0, 32'h12345678, 1, 2, 32'h0, 1'b0, 1);
    // half loads, both lane pairs
    do_txn("sh_ld",   32'h0000_0002, 1'b0, 2'b01, 1'b0, 32'h0, 0, 1, 32'h80017FFF, 1'b0, 0);
    do_txn("uh_ld",   32'h0000_0000, 1'b0, 2'b01, 1'b1, 32'h0, 0, 0, 32'h8001F234, 1'b0, 0);
    do_txn("sh_ld_lo", 32'h0000_0000, 1'b0, 2'b01, 1'b0, 32'h0, 2, 0, 32'h0001F234, 1'b0, 0);
    do_txn("w_st",    32'hFFFF_FFFC, 1'b1, 2'b10, 1'b0, 32'hA5A5_0FF0, 0, 0, 32'h0, 1'b0, 0);

    // reset while waiting for the response
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = 32'h0000_0020;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_size_i  = 2'b10;
    step();
    bus.cmd_valid_i = 1'b0;
    check("rst_mid:req", 32'(bus.obi_req_o), 1);
    bus.obi_gnt_i = 1'b1;
    step();
    bus.obi_gnt_i = 1'b0;
    check("rst_mid:rready", 32'(bus.obi_rready_o), 1);
    rst = 1'b1;
    step();
    check_all_zero("rst_mid", 1'b0);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_rel", 1'b1);
    do_txn("after_rst", 32'h0000_0024, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, 32'h0BADC0DE, 1'b0, 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
